mem_arbiter: RTL
================

# mem_arbiter

Byte-serial arbiter and sequencer for the single 8-bit RAM/I/O bus. It shares that bus between the instruction-fetch stage (always 4-byte reads) and the memory stage (1/2/4-byte loads and stores). It breaks each access into per-byte bus cycles that respect the 2-cycle read and 1-cycle write timing. It also assembles read data little-endian and returns a per-requester done pulse.

## Interface
- No parameters.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rdy_in  in  1  bus ready; low pauses issuing.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  32  fetch address; always a 4-byte read.
- if_done  out  1  one-cycle pulse; fetch data valid on rdata.
- dm_req  in  1  data request; held until dm_done.
- dm_we  in  1  1 = store, 0 = load.
- dm_size  in  2  0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data; byte 0 = [7:0].
- dm_done  out  1  one-cycle pulse; load data valid on rdata, or store complete.
- rdata  out  32  assembled read data, zero-extended. Sign extension is done by the requester.
- busy  out  1  high whenever the FSM is not IDLE.
- mem_din  in  8  RAM/I/O read byte.
- mem_dout  out  8  write byte.
- mem_a  out  32  byte address.
- mem_wr  out  1  1 = write.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE samples the requests at each clock edge.
  - Grant goes to the data port when dm_req=1; otherwise to the fetch port when if_req=1.
  - The grant latches owner, address, byte count n (1/2/4), write flag and wdata.
  - Next state is WRITE for a store, else READ.
- READ tracks two counters:
  - issue_cnt: each cycle with rdy_in=1 and issue_cnt<n drives mem_a=addr+issue_cnt, mem_wr=0, then increments.
  - cap_cnt: in the cycle after any issue, mem_din is written into rdata byte cap_cnt, then cap_cnt increments.
  - Capture is never gated by rdy_in.
  - When cap_cnt reaches n, go to DONE.
- WRITE: each cycle with rdy_in=1 drives mem_a=addr+k, mem_dout=wdata byte k, mem_wr=1, then k increments. After byte n-1, go to DONE.
- DONE:
  - Asserts the owner's done, and rdata is stable.
  - Stays in DONE while rdy_in=0, then returns to IDLE.
  - Requests are not sampled in DONE, so a requester can drop req in the cycle after done.
- mem_wr is forced to 0 combinationally whenever rdy_in=0. No byte is ever written twice, including I/O at 0x30000.
- When not issuing, mem_a holds its last value and mem_wr=0.
- Address arithmetic is 32-bit wrap-around. No alignment check.
- Reset values: state IDLE; mem_a, mem_dout, mem_wr, rdata, if_done, dm_done, busy all 0.
- Reset assertion at any point aborts the transaction and discards partial data. No done is produced.

## Timing
- Cycle numbering: request sampled at edge 0; cycle k follows edge k-1.
- Read of n bytes, rdy_in high throughout:
  - mem_a = addr..addr+n-1 in cycles 1..n.
  - Bytes captured at the end of cycles 2..n+1.
  - done in cycle n+2 (fetch: cycle 6).
- Write of n bytes, rdy_in high throughout: mem_wr=1 in cycles 1..n; done in cycle n+1.
- Each cycle of rdy_in=0 adds exactly one cycle to the transaction.
- Back-to-back: the earliest next grant is sampled at the edge ending the cycle after done. Minimum gap between transactions is one IDLE cycle.
- The arbiter is non-preemptive; grant changes only in IDLE.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on simultaneous requests.
  - A one-bit last_owner register (reset to fetch) is used; the port not served last wins the tie.
- MEM_ARB_RR_EN undefined: fixed priority, data port over fetch.
- Single requests behave identically in both builds.

## Test plan
- Fetch at 0x100, RAM 0x100..0x103 = 13 05 00 00 -> mem_a 0x100..0x103 in cycles 1-4, mem_wr=0, if_done in cycle 6, rdata=0x00000513.
- Store word 0xDEADBEEF at 0x2000 -> mem_wr=1 in cycles 1-4 with bytes EF,BE,AD,DE to 0x2000..0x2003, dm_done in cycle 5.
- if_req and dm_req rise together (dm load, 2 bytes) -> fixed-priority build serves the load first, then the fetch. RR build: after a prior dm grant, the fetch is served first.
- Store byte 0x41 to 0x30000 with rdy_in=0 in cycles 1-2 -> mem_wr=0 in cycles 1-2, mem_wr=1 exactly once in cycle 3, dm_done in cycle 4.
- Load word 0x400 (bytes 01 02 03 04), rdy_in=0 in cycle 3 only -> byte 0x02 still captured at end of cycle 3, dm_done in cycle 7, rdata=0x04030201.
- rst driven low in cycle 2 of a 4-byte store -> mem_wr=0 immediately (asynchronous), state IDLE, no dm_done. After release, a new request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial arbiter/sequencer sharing one 8-bit RAM/I/O bus
// between the instruction-fetch port (4-byte reads) and the memory-stage
// port (1/2/4-byte loads and stores). Reads take two cycles per byte
// (issue, then capture); writes take one. Read data is assembled
// little-endian and zero-extended.
//
// Build option: define MEM_ARB_RR_EN for round-robin tie-breaking between
// simultaneous requests; without it the data port has fixed priority.
//
// Handshake: a requester raises req with its address/data stable and holds
// all of them until its done pulses for one cycle. Requests are not sampled
// in the done cycle, so req may drop in the following cycle without
// producing a second grant. rdata is valid during the done cycle.
`timescale 1ns/1ps

module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [1:0]  dm_size,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_done,
    output logic [31:0] rdata,
    output logic        busy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

    state_t      state;
    logic        owner_dm;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  n_q;
    logic [2:0]  issue_cnt;
    logic [2:0]  cap_cnt;
    logic        cap_pend;
    logic [31:0] mem_a_q;
    logic [7:0]  mem_dout_q;

    function automatic logic [2:0] size_to_n(input logic [1:0] s);
        case (s)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Arbitration between the two ports, evaluated only while IDLE.
    logic grant_dm;
    logic grant_any;
`ifdef MEM_ARB_RR_EN
    logic last_dm;
    assign grant_dm = dm_req && (!if_req || !last_dm);
`else
    assign grant_dm = dm_req;
`endif
    assign grant_any = dm_req || if_req;

    logic        sel_we;
    logic [31:0] sel_addr;
    logic [2:0]  sel_n;
    assign sel_we   = grant_dm && dm_we;
    assign sel_addr = grant_dm ? dm_addr : if_addr;
    assign sel_n    = grant_dm ? size_to_n(dm_size) : 3'd4;

    // A bus cycle is issued only while rdy_in is high; otherwise the bus
    // address and write byte hold their last driven values.
    logic        rd_issue;
    logic        wr_issue;
    logic [31:0] issue_addr;
    logic [7:0]  issue_byte;
    assign rd_issue   = (state == READ) && rdy_in && (issue_cnt < n_q);
    assign wr_issue   = (state == WRITE) && rdy_in;
    assign issue_addr = addr_q + {29'd0, issue_cnt};
    assign issue_byte = wdata_q[{issue_cnt[1:0], 3'b000} +: 8];

    assign mem_a     = (rd_issue || wr_issue) ? issue_addr : mem_a_q;
    assign mem_dout  = wr_issue ? issue_byte : mem_dout_q;
    assign mem_wr    = wr_issue;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Sequencer: grant in IDLE, per-byte issue/capture in READ/WRITE, done pulse on entry to DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner_dm   <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            n_q        <= 3'd0;
            issue_cnt  <= 3'd0;
            cap_cnt    <= 3'd0;
            cap_pend   <= 1'b0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            rdata      <= 32'd0;
            if_done    <= 1'b0;
            dm_done    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_dm    <= 1'b0;
`endif
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            if (rd_issue || wr_issue) begin
                mem_a_q    <= mem_a;
                mem_dout_q <= mem_dout;
            end
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner_dm  <= grant_dm;
                        addr_q    <= sel_addr;
                        n_q       <= sel_n;
                        wdata_q   <= dm_wdata;
                        issue_cnt <= 3'd0;
                        cap_cnt   <= 3'd0;
                        cap_pend  <= 1'b0;
                        rdata     <= 32'd0;
`ifdef MEM_ARB_RR_EN
                        last_dm   <= grant_dm;
`endif
                        state     <= sel_we ? WRITE : READ;
                    end
                end
                READ: begin
                    // Capture follows every issue by one cycle, regardless of rdy_in.
                    cap_pend <= rd_issue;
                    if (rd_issue) begin
                        issue_cnt <= issue_cnt + 3'd1;
                    end
                    if (cap_pend) begin
                        rdata[{cap_cnt[1:0], 3'b000} +: 8] <= mem_din;
                        cap_cnt <= cap_cnt + 3'd1;
                        if (cap_cnt + 3'd1 == n_q) begin
                            state   <= DONE;
                            if_done <= !owner_dm;
                            dm_done <= owner_dm;
                        end
                    end
                end
                WRITE: begin
                    if (wr_issue) begin
                        issue_cnt <= issue_cnt + 3'd1;
                        if (issue_cnt + 3'd1 == n_q) begin
                            state   <= DONE;
                            if_done <= !owner_dm;
                            dm_done <= owner_dm;
                        end
                    end
                end
                DONE: begin
                    if (rdy_in) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
